weight_loader: RTL

- Host-side initiator for the layer weight-write bus (weight_data / weight_addr / weight_we) consumed by every conv layer's PE.
- Accepts a valid/ready stream of HOST_WIDTH-bit packets (header plus packed weight words) and unpacks them into one weight write per cycle, with incrementing addresses.
- Sits between the host register/DMA interface and the broadcast weight bus of all layers.

---
 rtl/weight_loader_pkg.sv | 25 ++
 rtl/weight_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: FSM state encoding,
// words-per-host-word derivation and the width compatibility check.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        S_ADDR,
        S_COUNT,
        S_LOAD,
        S_EMIT
    } state_t;

    localparam int ADDR_WIDTH = 32;

    // Weights carried by one host stream word.
    function automatic int pack_of(input int host_w, input int data_w);
        return host_w / data_w;
    endfunction

    // Host word must hold a whole number of weight words.
    function automatic bit width_ok(input int host_w, input int data_w);
        return (data_w > 0) && (host_w >= data_w)
            && (host_w % data_w == 0);
    endfunction

endpackage

// File: rtl/weight_loader.sv
// Weight loader: unpacks a valid/ready host packet (address, count,
// packed data words) into one weight-bus write per cycle.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   s_data        host stream word (HOST_WIDTH)
//   s_valid       s_data valid
//   s_ready       loader accepts s_data this cycle
//   weight_data   weight value (DATA_WIDTH, raw bits)
//   weight_addr   global weight address (32)
//   weight_we     write strobe, one write per high cycle
//   busy          high from header-address accept until done
//   load_done     one-cycle pulse at the end of a packet
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int HOST_WIDTH  = 32,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HOST_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] weight_data,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  weight_we,
    output logic                  busy,
    output logic                  load_done
);

    localparam int PACK = pack_of(HOST_WIDTH, DATA_WIDTH);
    localparam int SW   = (PACK > 1) ? $clog2(PACK) : 1;

    generate
        if (!width_ok(HOST_WIDTH, DATA_WIDTH)) begin : g_bad_width
            $error("HOST_WIDTH must be a multiple of DATA_WIDTH");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
    logic [SW-1:0]           slice_q, slice_d;
    logic [HOST_WIDTH-1:0]   sreg_q, sreg_d;

    logic                    s_ready_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [ADDR_WIDTH-1:0]   waddr_d;
    logic                    we_d;
    logic                    busy_d;
    logic                    done_d;

    logic                    xfer;
    logic [HOST_WIDTH-1:0]   shifted;
    logic [COUNT_WIDTH-1:0]  rem_dec;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    assign xfer     = s_valid && s_ready;
    assign shifted  = sreg_q >> DATA_WIDTH;
    assign rem_dec  = rem_q - COUNT_WIDTH'(1);
    assign addr_inc = addr_q + ADDR_WIDTH'(1);

    // In S_EMIT the output registers already show the current write:
    // addr_q is its address, rem_q counts it, sreg_q[DATA_WIDTH-1:0]
    // is its data. The cycle decides what the next edge presents.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        slice_d = slice_q;
        sreg_d  = sreg_q;
        wdata_d = weight_data;
        waddr_d = weight_addr;
        we_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;

        unique case (state_q)
            S_ADDR: begin
                if (xfer) begin
                    addr_d  = ADDR_WIDTH'(s_data);
                    busy_d  = 1'b1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    rem_d = s_data[COUNT_WIDTH-1:0];
                    if (s_data[COUNT_WIDTH-1:0] == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    sreg_d  = s_data;
                    slice_d = '0;
                    we_d    = 1'b1;
                    wdata_d = s_data[DATA_WIDTH-1:0];
                    waddr_d = addr_q;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                addr_d  = addr_inc;
                rem_d   = rem_dec;
                sreg_d  = shifted;
                slice_d = slice_q + SW'(1);
                if (rem_dec == '0) begin
                    // Upper slices of a partial word are dropped here.
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ADDR;
                end else if (slice_q == SW'(PACK - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = shifted[DATA_WIDTH-1:0];
                    waddr_d = addr_inc;
                end
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase

        s_ready_d = (state_d != S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ADDR;
            addr_q      <= '0;
            rem_q       <= '0;
            slice_q     <= '0;
            sreg_q      <= '0;
            s_ready     <= 1'b0;
            weight_data <= '0;
            weight_addr <= '0;
            weight_we   <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            slice_q     <= slice_d;
            sreg_q      <= sreg_d;
            s_ready     <= s_ready_d;
            weight_data <= wdata_d;
            weight_addr <= waddr_d;
            weight_we   <= we_d;
            busy        <= busy_d;
            load_done   <= done_d;
        end
    end

endmodule
